// File: rtl/fir_tap_sequencer.sv
// Time-multiplexed FIR: one 16x16 signed MAC walks TAPS taps over a circular
// sample buffer, then drains the two-stage multiply pipeline before presenting the result.
module fir_tap_sequencer #(
    parameter int TAPS = 32,
    parameter int AW   = 5
) (
    input  logic          aud_bclk,
    input  logic          rst_n,
    input  logic          rx_done,
    input  logic [15:0]   adc_data,
    output logic          coe_rd,
    output logic [AW-1:0] coe_addr,
    input  logic [15:0]   coe_data,
    output logic [33:0]   fir_data,
    output logic          fir_valid,
    output logic          busy,
    output logic          overrun
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             state_q;
    logic [AW-1:0]      wp_q;
    logic [AW-1:0]      k_q;
    logic [15:0]        buf_q [TAPS];
    logic signed [15:0] samp_q;
    logic               mac_vld_q;
    logic               drain_cnt_q;
    logic [33:0]        acc_q;
    logic [33:0]        fir_data_q;
    logic               fir_valid_q;
    logic               overrun_q;
    logic               coe_rd_q;

    logic [AW-1:0]      wp_d;
    logic [AW-1:0]      rd_idx;
    logic signed [31:0] prod;
    logic [33:0]        prod_ext;
    logic [33:0]        acc_d;

    // Address arithmetic is AW bits wide, so the circular wrap comes for free.
    assign wp_d     = wp_q + 1'b1;
    assign rd_idx   = wp_q - k_q;
    assign prod     = samp_q * $signed(coe_data);
    assign prod_ext = {{2{prod[31]}}, prod};
    assign acc_d    = acc_q + prod_ext;

    always_ff @(posedge aud_bclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wp_q        <= '0;
            k_q         <= '0;
            samp_q      <= '0;
            mac_vld_q   <= 1'b0;
            drain_cnt_q <= 1'b0;
            acc_q       <= '0;
            fir_data_q  <= '0;
            fir_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            coe_rd_q    <= 1'b0;
            for (int i = 0; i < TAPS; i++) buf_q[i] <= '0;
        end else begin
            fir_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            mac_vld_q   <= 1'b0;
            // Product for the sample registered last cycle meets its coefficient now.
            if (mac_vld_q) acc_q <= acc_d;
            case (state_q)
                IDLE: begin
                    if (rx_done) begin
                        buf_q[wp_d] <= adc_data;
                        wp_q        <= wp_d;
                        acc_q       <= '0;
                        k_q         <= '0;
                        coe_rd_q    <= 1'b1;
                        state_q     <= RUN;
                    end
                end
                RUN: begin
                    if (rx_done) overrun_q <= 1'b1;
                    samp_q    <= $signed(buf_q[rd_idx]);
                    mac_vld_q <= 1'b1;
                    if (k_q == AW'(TAPS - 1)) begin
                        k_q         <= '0;
                        coe_rd_q    <= 1'b0;
                        drain_cnt_q <= 1'b0;
                        state_q     <= DRAIN;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (rx_done) overrun_q <= 1'b1;
                    if (drain_cnt_q) begin
                        fir_data_q  <= acc_q;
                        fir_valid_q <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        drain_cnt_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign coe_rd    = coe_rd_q;
    assign coe_addr  = k_q;
    assign fir_data  = fir_data_q;
    assign fir_valid = fir_valid_q;
    assign busy      = (state_q != IDLE);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer: impulse, latency, overrun, back-to-back,
// accumulator wrap and mid-run reset, against hand-computed results.
module tb_fir_tap_sequencer;

    logic        aud_bclk = 1'b0;
    logic        rst_n;
    logic        rx_done;
    logic [15:0] adc_data;
    logic        coe_rd;
    logic [4:0]  coe_addr;
    logic [15:0] coe_data = '0;
    logic [33:0] fir_data;
    logic        fir_valid;
    logic        busy;
    logic        overrun;

    logic [15:0] coe_rom [32];
    logic [33:0] exp_q [$];
    int          total = 0;
    int          bad   = 0;

    fir_tap_sequencer #(.TAPS(32), .AW(5)) dut (
        .aud_bclk (aud_bclk),
        .rst_n    (rst_n),
        .rx_done  (rx_done),
        .adc_data (adc_data),
        .coe_rd   (coe_rd),
        .coe_addr (coe_addr),
        .coe_data (coe_data),
        .fir_data (fir_data),
        .fir_valid(fir_valid),
        .busy     (busy),
        .overrun  (overrun)
    );

    // clock / coefficient memory with one cycle read latency
    always #5 aud_bclk = ~aud_bclk;
    always @(posedge aud_bclk) coe_data <= coe_rom[coe_addr];

    task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic load_normal_rom();
        for (int i = 0; i < 32; i++) coe_rom[i] = 16'(i * 16'h0321 + 16'h0057);
        coe_rom[0]  = 16'hFF72;
        coe_rom[15] = 16'h6881;
    endtask

    task automatic load_wrap_rom();
        for (int i = 0; i < 32; i++) coe_rom[i] = 16'h8000;
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        rx_done  = 1'b0;
        adc_data = '0;
        repeat (3) @(negedge aud_bclk);
        rst_n = 1'b1;
        @(negedge aud_bclk);
    endtask

    // Called at a negedge with the DUT idle (or in its fir_valid cycle).
    // inj >= 0 places an extra rx_done so that it is sampled at edge E(inj).
    task automatic do_run(input logic [15:0] s, input int inj, output logic [33:0] res);
        rx_done  = 1'b1;
        adc_data = s;
        @(negedge aud_bclk);
        rx_done  = 1'b0;
        adc_data = '0;
        for (int n = 0; n <= 34; n++) begin
            check($sformatf("busy@E%0d", n), 34'(busy), 34'(n <= 33));
            check($sformatf("coe_rd@E%0d", n), 34'(coe_rd), 34'(n <= 31));
            check($sformatf("coe_addr@E%0d", n), 34'(coe_addr), (n <= 31) ? 34'(n) : 34'd0);
            check($sformatf("fir_valid@E%0d", n), 34'(fir_valid), 34'(n == 34));
            check($sformatf("overrun@E%0d", n), 34'(overrun), 34'(inj >= 0 && n == inj));
            if (inj >= 0 && n == inj - 1) begin
                rx_done  = 1'b1;
                adc_data = 16'h7FFF;
            end else begin
                rx_done  = 1'b0;
                adc_data = '0;
            end
            if (n < 34) @(negedge aud_bclk);
        end
        res = fir_data;
    endtask

    task automatic impulse_series();
        logic [33:0] res;
        for (int n = 0; n < 32; n++) exp_q.push_back({{18{coe_rom[n][15]}}, coe_rom[n]});
        for (int n = 0; n < 32; n++) begin
            do_run((n == 0) ? 16'h0001 : 16'h0000, -1, res);
            check($sformatf("impulse[%0d]", n), res, exp_q.pop_front());
            check($sformatf("imp_wp[%0d]", n), 34'(dut.wp_q), 34'((n + 1) % 32));
            if (n == 0)  check("impulse_first", res, 34'h3FFFFFF72);
            if (n == 15) check("impulse_15", res, 34'h000006881);
        end
    endtask

    initial begin
        logic [33:0] res;
        logic [33:0] r_ref;
        rst_n    = 1'b0;
        rx_done  = 1'b0;
        adc_data = '0;
        load_normal_rom();
        repeat (3) @(negedge aud_bclk);
        check("rst_fir_data", fir_data, 34'd0);
        check("rst_fir_valid", 34'(fir_valid), 34'd0);
        check("rst_busy", 34'(busy), 34'd0);
        check("rst_overrun", 34'(overrun), 34'd0);
        check("rst_coe_rd", 34'(coe_rd), 34'd0);
        check("rst_coe_addr", 34'(coe_addr), 34'd0);
        check("rst_wp", 34'(dut.wp_q), 34'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge aud_bclk);

        // Two samples: 3 then -2; second output = -2*coe0 + 3*coe1.
        do_run(16'h0003, -1, res);
        check("two_a", res, 34'h3FFFFFE56);
        do_run(16'hFFFE, -1, res);
        check("two_b", res, 34'h000000B84);
        repeat (5) @(negedge aud_bclk);
        check("hold_fir_data", fir_data, 34'h000000B84);
        check("hold_fir_valid", 34'(fir_valid), 34'd0);

        apply_reset();
        impulse_series();
        check("wp_wrap", 34'(dut.wp_q), 34'd0);

        // Overrun: dropped sample must not change the result or wp.
        apply_reset();
        do_run(16'h1234, -1, r_ref);
        check("ovr_ref", r_ref, 34'h3FFF5E728);
        apply_reset();
        do_run(16'h1234, 10, res);
        check("ovr_result", res, 34'h3FFF5E728);
        check("ovr_wp", 34'(dut.wp_q), 34'd1);

        // Wrap: m products of 2^30 accumulate modulo 2^34.
        load_wrap_rom();
        apply_reset();
        for (int m = 1; m <= 32; m++) begin
            do_run(16'h8000, -1, res);
            if (m == 1)  check("wrap_m1", res, 34'h040000000);
            if (m == 3)  check("wrap_m3", res, 34'h0C0000000);
            if (m == 16) check("wrap_m16", res, 34'h000000000);
            if (m == 32) check("wrap_m32", res, 34'h000000000);
        end
        check("wrap_wp", 34'(dut.wp_q), 34'd0);

        // Reset during RUN at E20.
        load_normal_rom();
        repeat (3) @(negedge aud_bclk);
        rx_done  = 1'b1;
        adc_data = 16'h0001;
        @(negedge aud_bclk);
        rx_done  = 1'b0;
        adc_data = '0;
        repeat (20) @(negedge aud_bclk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_fir_data", fir_data, 34'd0);
        check("mid_rst_fir_valid", 34'(fir_valid), 34'd0);
        check("mid_rst_busy", 34'(busy), 34'd0);
        check("mid_rst_overrun", 34'(overrun), 34'd0);
        check("mid_rst_coe_rd", 34'(coe_rd), 34'd0);
        check("mid_rst_coe_addr", 34'(coe_addr), 34'd0);
        check("mid_rst_wp", 34'(dut.wp_q), 34'd0);
        repeat (3) @(negedge aud_bclk);
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge aud_bclk);
            check($sformatf("post_rst_valid[%0d]", c), 34'(fir_valid), 34'd0);
            check($sformatf("post_rst_busy[%0d]", c), 34'(busy), 34'd0);
        end
        impulse_series();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fir_tap_sequencer.md
FIR_TAP_SEQUENCER -- requirements
Module: fir_tap_sequencer

Interface
REQ-001 The module SHALL have exactly one clock, aud_bclk, and an asynchronous active-low reset, rst_n; all state SHALL be clocked on the aud_bclk rising edge and cleared immediately on rst_n low.
REQ-002 Parameter: TAPS, default 32, number of filter taps; the value SHALL be a power of two.
REQ-003 Parameter: AW, default 5, address width; it SHALL equal log2(TAPS).
REQ-004 aud_bclk  input  1  audio bit clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 rx_done  input  1  one-cycle pulse; adc_data is valid in the same cycle.
REQ-007 adc_data  input  16  new audio sample, signed two's complement.
REQ-008 coe_rd  output  1  coefficient read enable, high while the state is RUN.
REQ-009 coe_addr  output  AW  coefficient index k.
REQ-010 coe_data  input  16  signed coefficient, valid exactly 1 cycle after coe_rd/coe_addr.
REQ-011 fir_data  output  34  filter result, signed.
REQ-012 fir_valid  output  1  one-cycle pulse qualifying fir_data.
REQ-013 busy  output  1  high whenever the state is not IDLE.
REQ-014 overrun  output  1  one-cycle pulse: an rx_done arrived while busy and its sample was dropped.

Function
REQ-015 The module SHALL time-multiplex one 16x16 signed MAC over TAPS taps, replacing a fully parallel multiplier array.
REQ-016 Sample storage SHALL be an internal circular buffer of TAPS x 16 bits with write pointer wp (AW bits), which wraps from TAPS-1 to 0.
REQ-017 The FSM SHALL have the states IDLE, RUN and DRAIN.
REQ-018 In IDLE, an rx_done sampled at edge E0 SHALL write buf[wp+1] = adc_data, set wp = wp+1, clear acc, set k = 0 and enter RUN.
REQ-019 RUN SHALL last TAPS cycles; each cycle it SHALL drive coe_addr = k, register samp_q = buf[wp-k] (modulo TAPS), and increment k.
REQ-020 Tap 0 SHALL be the newest sample.
REQ-021 The accumulator SHALL add sext34(samp_q*coe_data) for tap k at edge E(k+2).
REQ-022 After k = TAPS-1 is issued (edge E(TAPS)), the FSM SHALL enter DRAIN for 2 cycles so the last two products accumulate.
REQ-023 At edge E(TAPS+2) (E34 at the default TAPS), the module SHALL set fir_data = acc and fir_valid = 1 for one cycle, and return to IDLE.
REQ-024 Products SHALL be the full 32-bit signed product sign-extended to 34 bits.
REQ-025 acc SHALL be 34 bits and wrap modulo 2^34, with no saturation.
REQ-026 fir_data SHALL hold its value until the next fir_valid.
REQ-027 rx_done while busy (RUN or DRAIN) SHALL drop the sample, leave the buffer, wp and computation unchanged, and pulse overrun in the following cycle.
REQ-028 rx_done in the same cycle that fir_valid is high SHALL be accepted, because the state is IDLE in that cycle.
REQ-029 coe_addr SHALL be 0 and coe_rd SHALL be 0 outside RUN.
REQ-030 busy SHALL be high from edge E0 through the cycle before fir_valid.

Reset
REQ-031 On rst_n low, the module SHALL set state=IDLE, wp=0, k=0, acc=0, every buffer entry=0, fir_data=0, fir_valid=0, busy=0, overrun=0, coe_rd=0 and coe_addr=0.
REQ-032 A reset during RUN or DRAIN SHALL abort the computation with no fir_valid; operation SHALL resume on the first rx_done after rst_n goes high.

Verification
REQ-033 Impulse (coefficient model: coe[0]=16'hFF72, coe[15]=16'h6881): after reset, adc_data=16'h0001 then 31 samples of 0 -> output n SHALL equal sext34(coe[n]); the first output SHALL be 34'h3FFFFFF72 and output 15 SHALL be 34'h000006881.
REQ-034 Latency: rx_done at E0 -> fir_valid high only in the cycle after E34, busy high E0..E33, and coe_addr stepping 0..31 over E0..E31.
REQ-035 Overrun: second rx_done (adc_data=16'h7FFF) at E10 -> overrun pulse, fir_data identical to the run without it, and wp advanced by 1 only.
REQ-036 Back-to-back: rx_done in the fir_valid cycle -> accepted, next fir_valid 34 cycles later, and no overrun.
REQ-037 Wrap: all samples 16'h8000 and all coe 16'h8000 -> each product 2^30, sum 2^35 mod 2^34, so fir_data=34'h000000000; the bench SHALL also check wp wrap from 31 to 0 after 32 accepted samples.
REQ-038 Reset at E20 of a run -> fir_valid never asserted, all outputs 0, and the next impulse test reproduces REQ-033 exactly.
